// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the board SRAM read arbiter.
//   owner_t     : tag carried with each access through the issue/capture pipeline
//   SRAM_ADDR_W : SRAM word address width
//   SRAM_DATA_W : SRAM data width
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_S0,
        OWN_S1
    } owner_t;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   req_i    : request bits, one per requester
//   rr_i     : priority pointer; the requester it names wins a tie
//   enable_i : when low, no grant is issued
//   gnt_o    : one-hot grant (all-zero when disabled or idle)
// The pointer itself is kept by the caller so it can decide when a grant
// counts as "used".
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       rr_i,
    input  logic       enable_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (enable_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = rr_i ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// Read arbiter for the single 16-bit board SRAM.
// The display owns every even (phase 0) cycle it asks for; all other cycles go
// round-robin to the sprite fetch (requester 0) and platform scanner
// (requester 1). Fixed two-cycle read latency for every owner.
//   Clk, Reset             : system clock, synchronous active-high reset
//   disp_req/addr          : display request for the current phase 0 slot
//   disp_data/valid        : returned display word and its one-cycle strobe
//   sec_req/addr0/addr1    : secondary requests, held until sec_gnt
//   sec_gnt                : combinational one-hot grant (address accepted)
//   sec_data/valid         : returned secondary word, one-hot strobe
//   SRAM_*                 : registered SRAM pins, read-only (WE_N tied high)
module sram_read_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic [1:0]        sec_req,
    input  logic [ADDR_W-1:0] sec_addr0,
    input  logic [ADDR_W-1:0] sec_addr1,
    output logic [1:0]        sec_gnt,
    output logic [DATA_W-1:0] sec_data,
    output logic [1:0]        sec_valid,
    input  logic [DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_WE_N
);

    logic              phase_q, phase_d;
    logic              rr_q, rr_d;
    owner_t            iss_own_q, iss_own_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic              sram_ctl_n_q, sram_ctl_n_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] sec_data_q, sec_data_d;
    logic [1:0]        sec_valid_q, sec_valid_d;

    logic              disp_win;
    logic [1:0]        arb_gnt;

    // Display only claims phase 0; an idle display slot falls through.
    assign disp_win = ~phase_q & disp_req;

    // Gate with Reset so no grant is accepted in a cycle whose issue is discarded.
    rr_arbiter2 u_rr_arbiter2 (
        .req_i    (sec_req),
        .rr_i     (rr_q),
        .enable_i (~disp_win & ~Reset),
        .gnt_o    (arb_gnt)
    );

    assign sec_gnt = arb_gnt;

    // Issue decision and pointer update.
    always_comb begin
        iss_own_d   = OWN_NONE;
        sram_addr_d = sram_addr_q;
        rr_d        = rr_q;
        phase_d     = ~phase_q;
        if (disp_win) begin
            iss_own_d   = OWN_DISP;
            sram_addr_d = disp_addr;
        end else if (arb_gnt[0]) begin
            iss_own_d   = OWN_S0;
            sram_addr_d = sec_addr0;
            rr_d        = 1'b1;
        end else if (arb_gnt[1]) begin
            iss_own_d   = OWN_S1;
            sram_addr_d = sec_addr1;
            rr_d        = 1'b0;
        end
        sram_ctl_n_d = (iss_own_d == OWN_NONE);
    end

    // Capture and steering are merged: SRAM_DQ is sampled straight into the
    // owner's output register so the strobe lands two cycles after the grant,
    // and data registers only load on their own strobe so they hold otherwise.
    always_comb begin
        disp_data_d  = disp_data_q;
        sec_data_d   = sec_data_q;
        disp_valid_d = (iss_own_q == OWN_DISP);
        sec_valid_d  = {iss_own_q == OWN_S1, iss_own_q == OWN_S0};
        if (iss_own_q == OWN_DISP) begin
            disp_data_d = SRAM_DQ;
        end
        if ((iss_own_q == OWN_S0) || (iss_own_q == OWN_S1)) begin
            sec_data_d = SRAM_DQ;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_q      <= 1'b0;
            rr_q         <= 1'b0;
            iss_own_q    <= OWN_NONE;
            sram_addr_q  <= '0;
            sram_ctl_n_q <= 1'b1;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            sec_data_q   <= '0;
            sec_valid_q  <= 2'b00;
        end else begin
            phase_q      <= phase_d;
            rr_q         <= rr_d;
            iss_own_q    <= iss_own_d;
            sram_addr_q  <= sram_addr_d;
            sram_ctl_n_q <= sram_ctl_n_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            sec_data_q   <= sec_data_d;
            sec_valid_q  <= sec_valid_d;
        end
    end

    assign SRAM_ADDR  = sram_addr_q;
    assign SRAM_CE_N  = sram_ctl_n_q;
    assign SRAM_OE_N  = sram_ctl_n_q;
    assign SRAM_UB_N  = sram_ctl_n_q;
    assign SRAM_LB_N  = sram_ctl_n_q;
    assign SRAM_WE_N  = 1'b1;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign sec_data   = sec_data_q;
    assign sec_valid  = sec_valid_q;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: directed phases plus random traffic, checked
// every cycle against a slot-level reference model of the arbitration rules.
module tb_sram_read_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        disp_req;
    logic [19:0] disp_addr;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic [1:0]  sec_req;
    logic [19:0] sec_addr0;
    logic [19:0] sec_addr1;
    logic [1:0]  sec_gnt;
    logic [15:0] sec_data;
    logic [1:0]  sec_valid;
    logic [15:0] SRAM_DQ;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_WE_N;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sram_read_arbiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .sec_req    (sec_req),
        .sec_addr0  (sec_addr0),
        .sec_addr1  (sec_addr1),
        .sec_gnt    (sec_gnt),
        .sec_data   (sec_data),
        .sec_valid  (sec_valid),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    // SRAM contents: low address bits with the high nibble folded in.
    function automatic logic [15:0] sram_word(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'h000};
    endfunction

    assign SRAM_DQ = sram_word(SRAM_ADDR);

    // Reference model. Owners: 0 none, 1 display, 2 sprite, 3 scanner.
    int          m_phase, m_rr, m_iss, m_val, dec_own;
    logic [19:0] m_pin, dec_addr;
    logic [15:0] m_dhold, m_shold;
    logic [1:0]  exp_gnt, last_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_iss = 0; m_val = 0;
        m_pin = '0; m_dhold = '0; m_shold = '0;
    endtask

    // One clock: decide the slot from the rules, check all outputs at the
    // negedge, then advance the model at the posedge.
    task automatic run_cycle();
        int win;
        @(negedge Clk);
        exp_gnt  = 2'b00;
        dec_own  = 0;
        dec_addr = '0;
        if (!Reset) begin
            if (m_phase == 0 && disp_req) begin
                dec_own  = 1;
                dec_addr = disp_addr;
            end else begin
                win = -1;
                if (sec_req == 2'b11)      win = m_rr;
                else if (sec_req == 2'b01) win = 0;
                else if (sec_req == 2'b10) win = 1;
                if (win >= 0) begin
                    exp_gnt[win] = 1'b1;
                    dec_own      = 2 + win;
                    dec_addr     = (win == 1) ? sec_addr1 : sec_addr0;
                end
            end
        end
        chk("sec_gnt",    sec_gnt,    exp_gnt);
        chk("ce_n",       SRAM_CE_N,  m_iss == 0);
        chk("oe_n",       SRAM_OE_N,  m_iss == 0);
        chk("ub_n",       SRAM_UB_N,  m_iss == 0);
        chk("lb_n",       SRAM_LB_N,  m_iss == 0);
        chk("we_n",       SRAM_WE_N,  1);
        chk("sram_addr",  SRAM_ADDR,  m_pin);
        chk("disp_valid", disp_valid, m_val == 1);
        chk("sec_valid",  sec_valid,  {m_val == 3, m_val == 2});
        chk("disp_data",  disp_data,  m_dhold);
        chk("sec_data",   sec_data,   m_shold);
        last_gnt = exp_gnt;
        @(posedge Clk);
        if (Reset) begin
            model_reset();
        end else begin
            m_val = m_iss;
            if (m_iss == 1) m_dhold = sram_word(m_pin);
            if (m_iss >= 2) m_shold = sram_word(m_pin);
            m_iss = dec_own;
            if (dec_own != 0) m_pin = dec_addr;
            if (dec_own == 2) m_rr = 1;
            if (dec_own == 3) m_rr = 0;
            m_phase = 1 - m_phase;
        end
        #1;
    endtask

    // Requesters obey the handshake: a pending, ungranted request is held.
    task automatic drive_sec(input logic [1:0] want, input bit fixed, input logic [19:0] faddr);
        logic [31:0] r;
        for (int i = 0; i < 2; i++) begin
            if (!(sec_req[i] && !last_gnt[i])) begin
                sec_req[i] = want[i];
                r = $urandom;
                if (fixed) r[19:0] = faddr;
                if (i == 0) sec_addr0 = r[19:0];
                else        sec_addr1 = r[19:0];
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [19:0] k;
        Reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
        sec_req = 2'b00; sec_addr0 = '0; sec_addr1 = '0;
        last_gnt = 2'b00;
        model_reset();
        @(posedge Clk); #1;

        // Reset held 3 cycles with requests present: no grants, idle pins.
        disp_req = 1'b1; sec_req = 2'b11;
        repeat (3) run_cycle();
        Reset = 1'b0; disp_req = 1'b0; sec_req = 2'b00;

        // Display only, addresses 0x10, 0x11, ... one per phase 0 slot.
        k = 20'h00010;
        disp_req = 1'b1;
        repeat (12) begin
            disp_addr = k;
            run_cycle();
            if (dec_own == 1) k = k + 1;
        end

        // Contention: display plus both secondaries continuously.
        repeat (16) begin
            drive_sec(2'b11, 1'b0, '0);
            disp_addr = k;
            run_cycle();
            if (dec_own == 1) k = k + 1;
        end

        // Fall-through: sprite alone streams at one access per cycle.
        disp_req = 1'b0;
        repeat (10) begin
            drive_sec(2'b01, 1'b1, 20'h12345);
            run_cycle();
        end

        // Idle.
        repeat (12) begin
            drive_sec(2'b00, 1'b0, '0);
            run_cycle();
        end

        // Random traffic.
        repeat (60) begin
            r = $urandom;
            disp_req  = r[20];
            disp_addr = r[19:0];
            drive_sec(r[22:21], 1'b0, '0);
            run_cycle();
        end

        // Mid-flight reset: scanner granted, reset the following cycle.
        disp_req = 1'b0;
        repeat (4) begin
            drive_sec(2'b00, 1'b0, '0);
            run_cycle();
        end
        sec_req = 2'b10; sec_addr1 = 20'hABCDE;
        run_cycle();
        sec_req = 2'b00; Reset = 1'b1;
        run_cycle();
        run_cycle();
        Reset = 1'b0;
        repeat (4) run_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
